// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and in-order load returns onto the single regfile write port,
// tracks outstanding load destinations and raises a decode stall. Define WB_FWD_EN for output-register forwarding.
module wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  output logic              ld_ready,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  output logic              stall,
  output logic              ld_err,
`ifdef WB_FWD_EN
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
`endif
  output logic              we,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] indata
);

  localparam int PTR_W = $clog2(LD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]   slot_rd_reg [LD_DEPTH];
  logic [LD_DEPTH-1:0] slot_valid_reg;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;

  logic              we_reg, we_next;
  logic [ADDR_W-1:0] rd_reg, rd_next;
  logic [DATA_W-1:0] indata_reg, indata_next;
  logic              ld_err_reg, ld_err_next;

  logic              fifo_empty, push, pop;
  logic [ADDR_W-1:0] head_rd;

  assign fifo_empty = (count_reg == '0);
  assign ld_ready   = (count_reg != CNT_W'(LD_DEPTH));
  assign push       = ld_issue && ld_ready;
  assign pop        = ld_valid && !fifo_empty;
  assign head_rd    = slot_rd_reg[rd_ptr_reg];
  assign alu_ready  = !ld_valid;

  // Push and pop never address the same slot: that needs the FIFO both empty and full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_reg <= '0;
      for (int i = 0; i < LD_DEPTH; i++) slot_rd_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        slot_valid_reg[wr_ptr_reg] <= 1'b1;
        slot_rd_reg[wr_ptr_reg]    <= ld_issue_rd;
        wr_ptr_reg                 <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        slot_valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg                 <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Per-slot destination matches against the decode operands; x0 is masked after the OR.
  logic [LD_DEPTH-1:0] hit_rs1, hit_rs2, hit_rd;
  generate
    for (genvar gi = 0; gi < LD_DEPTH; gi++) begin : g_match
      assign hit_rs1[gi] = slot_valid_reg[gi] && (slot_rd_reg[gi] == id_rs1);
      assign hit_rs2[gi] = slot_valid_reg[gi] && (slot_rd_reg[gi] == id_rs2);
      assign hit_rd[gi]  = slot_valid_reg[gi] && (slot_rd_reg[gi] == id_rd);
    end
  endgenerate

  logic busy_rs1, busy_rs2, busy_rd, wb_hit1, wb_hit2;
  assign busy_rs1 = (|hit_rs1) && (id_rs1 != '0);
  assign busy_rs2 = (|hit_rs2) && (id_rs2 != '0);
  assign busy_rd  = (|hit_rd)  && (id_rd  != '0);
  assign wb_hit1  = we_reg && (rd_reg != '0) && (rd_reg == id_rs1);
  assign wb_hit2  = we_reg && (rd_reg != '0) && (rd_reg == id_rs2);

`ifdef WB_FWD_EN
  assign fwd1_hit  = wb_hit1;
  assign fwd2_hit  = wb_hit2;
  assign fwd1_data = indata_reg;
  assign fwd2_data = indata_reg;
  assign stall     = busy_rs1 || busy_rs2 || busy_rd;
`else
  assign stall     = busy_rs1 || busy_rs2 || busy_rd || wb_hit1 || wb_hit2;
`endif

  always_comb begin
    we_next     = 1'b0;
    rd_next     = rd_reg;
    indata_next = indata_reg;
    ld_err_next = ld_err_reg || (ld_valid && fifo_empty);
    if (pop) begin
      we_next     = (head_rd != '0);
      rd_next     = head_rd;
      indata_next = ld_data;
    end else if (alu_valid) begin
      we_next     = (alu_rd != '0);
      rd_next     = alu_rd;
      indata_next = alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg     <= 1'b0;
      rd_reg     <= '0;
      indata_reg <= '0;
      ld_err_reg <= 1'b0;
    end else begin
      we_reg     <= we_next;
      rd_reg     <= rd_next;
      indata_reg <= indata_next;
      ld_err_reg <= ld_err_next;
    end
  end

  assign we     = we_reg;
  assign rd     = rd_reg;
  assign indata = indata_reg;
  assign ld_err = ld_err_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: table of per-cycle vectors with a writeback scoreboard, plus reset/error sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_issue, ld_valid;
  logic [4:0]  alu_rd, ld_issue_rd, id_rs1, id_rs2, id_rd;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, stall, ld_err, we;
  logic [4:0]  rd;
  logic [31:0] indata;
`ifdef WB_FWD_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .LD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_ready(ld_ready),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .stall(stall), .ld_err(ld_err),
`ifdef WB_FWD_EN
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .we(we), .rd(rd), .indata(indata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] av, ard, adata, li, lird, lv, ldata, rs1, rs2, idrd;
    logic [31:0] e_aready, e_lready, e_stall, e_sfwd, e_we, e_rd, e_data, e_err;
  } vec_t;

  typedef struct {
    logic [31:0] we, rd, data, err;
  } exp_t;

  vec_t vecs [22];
  exp_t sbq [$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  initial begin
    exp_t        e;
    logic [31:0] pwe, prd, pdata;
    // av ard adata | li lird | lv ldata | rs1 rs2 idrd || aready lready stall sfwd | we rd data err
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0,  0, 0,     5,  0, 0,  1, 1, 0, 0,  1, 5,  32'hDEADBEEF, 0};
    vecs[1]  = '{0, 0, 0,            0, 0,  0, 0,     5,  0, 0,  1, 1, 1, 0,  0, 5,  32'hDEADBEEF, 0};
    vecs[2]  = '{0, 0, 0,            1, 3,  0, 0,     0,  0, 0,  1, 1, 0, 0,  0, 5,  32'hDEADBEEF, 0};
    vecs[3]  = '{0, 0, 0,            1, 3,  0, 0,     0,  3, 0,  1, 1, 1, 1,  0, 5,  32'hDEADBEEF, 0};
    vecs[4]  = '{0, 0, 0,            0, 0,  1, 32'h11, 0, 3, 0,  0, 1, 1, 1,  1, 3,  32'h11, 0};
    vecs[5]  = '{0, 0, 0,            0, 0,  1, 32'h22, 0, 3, 0,  0, 1, 1, 1,  1, 3,  32'h22, 0};
    vecs[6]  = '{0, 0, 0,            0, 0,  0, 0,     0,  3, 0,  1, 1, 1, 0,  0, 3,  32'h22, 0};
    vecs[7]  = '{0, 0, 0,            0, 0,  0, 0,     0,  3, 0,  1, 1, 0, 0,  0, 3,  32'h22, 0};
    vecs[8]  = '{0, 0, 0,            1, 7,  0, 0,     0,  0, 0,  1, 1, 0, 0,  0, 3,  32'h22, 0};
    vecs[9]  = '{1, 8, 32'h88,       0, 0,  1, 32'h77, 0, 0, 0,  0, 1, 0, 0,  1, 7,  32'h77, 0};
    vecs[10] = '{1, 8, 32'h88,       0, 0,  0, 0,     0,  0, 0,  1, 1, 0, 0,  1, 8,  32'h88, 0};
    vecs[11] = '{0, 0, 0,            1, 0,  0, 0,     0,  0, 0,  1, 1, 0, 0,  0, 8,  32'h88, 0};
    vecs[12] = '{0, 0, 0,            1, 9,  0, 0,     0,  0, 0,  1, 1, 0, 0,  0, 8,  32'h88, 0};
    vecs[13] = '{0, 0, 0,            1, 10, 0, 0,     0,  0, 9,  1, 1, 1, 1,  0, 8,  32'h88, 0};
    vecs[14] = '{0, 0, 0,            1, 11, 0, 0,     0,  0, 0,  1, 1, 0, 0,  0, 8,  32'h88, 0};
    vecs[15] = '{0, 0, 0,            1, 12, 0, 0,     12, 0, 0,  1, 0, 0, 0,  0, 8,  32'h88, 0};
    vecs[16] = '{0, 0, 0,            0, 0,  1, 32'hA0, 11, 0, 0, 0, 0, 1, 1,  0, 0,  32'hA0, 0};
    vecs[17] = '{0, 0, 0,            0, 0,  1, 32'h99, 0, 0, 0,  0, 1, 0, 0,  1, 9,  32'h99, 0};
    vecs[18] = '{0, 0, 0,            0, 0,  1, 32'hAA, 10, 0, 0, 0, 1, 1, 1,  1, 10, 32'hAA, 0};
    vecs[19] = '{0, 0, 0,            0, 0,  1, 32'hBB, 0, 10, 0, 0, 1, 1, 0,  1, 11, 32'hBB, 0};
    vecs[20] = '{0, 0, 0,            0, 0,  1, 32'hCC, 0, 0, 0,  0, 1, 0, 0,  0, 11, 32'hBB, 1};
    vecs[21] = '{0, 0, 0,            0, 0,  0, 0,     0,  0, 0,  1, 1, 0, 0,  0, 11, 32'hBB, 1};

    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_indata", indata, 0);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    pwe = 0; prd = 0; pdata = 0;
    for (int i = 0; i < 22; i++) begin
      alu_valid = vecs[i].av[0];   alu_rd = vecs[i].ard[4:0];       alu_data = vecs[i].adata;
      ld_issue = vecs[i].li[0];    ld_issue_rd = vecs[i].lird[4:0];
      ld_valid = vecs[i].lv[0];    ld_data = vecs[i].ldata;
      id_rs1 = vecs[i].rs1[4:0];   id_rs2 = vecs[i].rs2[4:0];       id_rd = vecs[i].idrd[4:0];
      sbq.push_back('{vecs[i].e_we, vecs[i].e_rd, vecs[i].e_data, vecs[i].e_err});
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), vecs[i].e_aready);
      chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), vecs[i].e_lready);
`ifdef WB_FWD_EN
      chk($sformatf("v%0d_stall", i), 32'(stall), vecs[i].e_sfwd);
      chk($sformatf("v%0d_fwd1_hit", i), 32'(fwd1_hit),
          32'(pwe[0] && prd != 0 && prd == vecs[i].rs1));
      chk($sformatf("v%0d_fwd2_hit", i), 32'(fwd2_hit),
          32'(pwe[0] && prd != 0 && prd == vecs[i].rs2));
      if (pwe[0]) chk($sformatf("v%0d_fwd_data", i), fwd1_data, pdata);
`else
      chk($sformatf("v%0d_stall", i), 32'(stall), vecs[i].e_stall);
`endif
      @(posedge clk); #1;
      if (sbq.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", i), 1, 0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_we", i), 32'(we), e.we);
        chk($sformatf("v%0d_rd", i), 32'(rd), e.rd);
        chk($sformatf("v%0d_indata", i), indata, e.data);
        chk($sformatf("v%0d_ld_err", i), 32'(ld_err), e.err);
      end
      $display("vec %0d: we=%b rd=%0d indata=%h stall=%b ld_err=%b", i, we, rd, indata, stall, ld_err);
      pwe = vecs[i].e_we; prd = vecs[i].e_rd; pdata = vecs[i].e_data;
    end

    // Mid-stream reset: a pending load to x4 and a fresh ALU write must vanish without a clock edge.
    drive_idle();
    ld_issue = 1; ld_issue_rd = 4;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    @(posedge clk); #1;
    chk("pre_rst_we", 32'(we), 1);
    chk("pre_rst_indata", indata, 32'h66);
    drive_idle();
    id_rs1 = 4;
    #1;
    chk("pre_rst_stall", 32'(stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(we), 0);
    chk("async_rst_rd", 32'(rd), 0);
    chk("async_rst_indata", indata, 0);
    chk("async_rst_ld_ready", 32'(ld_ready), 1);
    chk("async_rst_stall", 32'(stall), 0);
    chk("async_rst_ld_err", 32'(ld_err), 0);
    $display("reset: we=%b rd=%0d indata=%h ld_ready=%b stall=%b ld_err=%b",
             we, rd, indata, ld_ready, stall, ld_err);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // The load issued before reset now returns: it was discarded, so this is an error return.
    ld_valid = 1; ld_data = 32'h55;
    @(posedge clk); #1;
    drive_idle();
    chk("late_ret_ld_err", 32'(ld_err), 1);
    chk("late_ret_we", 32'(we), 0);
    $display("late return: we=%b ld_err=%b", we, ld_err);
    @(posedge clk); #1;
    chk("late_ret_ld_err_sticky", 32'(ld_err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
